// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the time-multiplexed "0110" detector.
//   - det_state_t : 3-bit detector state type
//   - S0..S4      : state encodings (S4 means a "0110" has just completed)
//   - HIT_STATE   : state that signals a completed pattern
//   - next_state  : pure transition function of the pattern detector
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef logic [2:0] det_state_t;

    localparam logic [2:0] S0 = 3'd0;  // nothing matched
    localparam logic [2:0] S1 = 3'd1;  // "0"
    localparam logic [2:0] S2 = 3'd2;  // "01"
    localparam logic [2:0] S3 = 3'd3;  // "011"
    localparam logic [2:0] S4 = 3'd4;  // "0110" complete

    localparam logic [2:0] HIT_STATE = S4;

    // Detector transition. S4 behaves like S1 because the trailing "0" of a
    // completed pattern is also the leading "0" of the next one (overlap).
    // Unused encodings recover to S0.
    function automatic logic [2:0] next_state(input logic [2:0] state,
                                              input logic       din);
        logic [2:0] nxt;
        nxt = S0;
        case (state)
            S0:      nxt = din ? S0 : S1;
            S1:      nxt = din ? S2 : S1;
            S2:      nxt = din ? S3 : S1;
            S3:      nxt = din ? S0 : S4;
            S4:      nxt = din ? S2 : S1;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter granting at most one requester per cycle. The search
// starts at the internal pointer and wraps; after an accepted grant the
// pointer moves to the slot just past the winner, otherwise it holds.
//
// Ports:
//   clk      in   clock
//   rstn     in   asynchronous active-low reset (pointer -> 0)
//   req      in   NCH request vector
//   adv      in   the current grant was accepted; advance the pointer
//   gnt      out  one-hot grant (all-zero when nothing requests), combinational
//   gnt_idx  out  binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int IDW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] gnt_idx
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NCH - 1);

    logic [IDW-1:0] ptr_r;
    logic [NCH-1:0] gnt_s;
    logic [IDW-1:0] gnt_idx_s;
    logic           found_s;

    // Wrapping priority search: first the slots at/after the pointer, then
    // the slots below it. Loop indices are constants, so each bit of the
    // grant is a plain priority chain.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found_s && req[i] && (32'(ptr_r) <= 32'(i))) begin
                found_s   = 1'b1;
                gnt_s[i]  = 1'b1;
                gnt_idx_s = IDW'(i);
            end else begin
                found_s   = found_s;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found_s && req[i]) begin
                found_s   = 1'b1;
                gnt_s[i]  = 1'b1;
                gnt_idx_s = IDW'(i);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Pointer register: moves past the winner on an accepted grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (adv) begin
            ptr_r <= (gnt_idx_s == LAST_IDX) ? '0 : (gnt_idx_s + IDW'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = gnt_idx_s;

endmodule

// File: rtl/seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// seq_det_scheduler
// One "0110" detector shared by NCH bit-serial channels. A round-robin
// arbiter accepts at most one bit per cycle; the winner's saved detector
// state is advanced and written back to its context register. A completed
// pattern produces a one-cycle registered hit pulse tagged with the channel
// and bumps that channel's saturating hit counter.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   en         in   global enable; no grants while low
//   in_valid   in   [NCH]  per-channel bit valid
//   in_bit     in   [NCH]  per-channel serial data bit
//   in_ready   out  [NCH]  per-channel accept (one-hot or zero), combinational
//   ch_clr     in   [NCH]  per-channel synchronous clear of context + counter
//   hit_valid  out         registered one-cycle hit pulse
//   hit_ch     out  [IDW]  channel of the reported hit
//   cnt_sel    in   [IDW]  hit counter read select
//   cnt_val    out  [CW]   hit counter of channel cnt_sel (0 when out of range)
// -----------------------------------------------------------------------------
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int CW  = 8,
    localparam int IDW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] ch_clr,
    output logic           hit_valid,
    output logic [IDW-1:0] hit_ch,
    input  logic [IDW-1:0] cnt_sel,
    output logic [CW-1:0]  cnt_val
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    det_state_t     ctx_r [NCH];
    logic [CW-1:0]  cnt_r [NCH];
    logic           hit_valid_r;
    logic [IDW-1:0] hit_ch_r;

    logic [NCH-1:0] req_s;
    logic [NCH-1:0] gnt_s;
    logic [IDW-1:0] gnt_idx_s;
    logic           xfer_s;
    det_state_t     nxt_s;
    logic           hit_now_s;
    logic [CW-1:0]  cnt_val_s;

    // A channel under clear is never granted, so a clear always wins over a
    // transfer and no bit is consumed in that cycle.
    assign req_s = en ? (in_valid & ~ch_clr) : '0;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_s),
        .adv     (xfer_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Grants only go to valid channels, so any grant is a transfer.
    assign xfer_s    = |(gnt_s & in_valid);
    assign nxt_s     = next_state(ctx_r[gnt_idx_s], in_bit[gnt_idx_s]);
    assign hit_now_s = xfer_s && (nxt_s == HIT_STATE);

    // Per-channel context: cleared on ch_clr, written back on its own grant,
    // otherwise held so idle gaps keep the partial match.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_r[i] <= S0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    ctx_r[i] <= S0;
                end else if (gnt_s[i] && xfer_s) begin
                    ctx_r[i] <= nxt_s;
                end else begin
                    ctx_r[i] <= ctx_r[i];
                end
            end
        end
    end

    // Per-channel saturating hit counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    cnt_r[i] <= '0;
                end else if (gnt_s[i] && hit_now_s && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Hit report register: pulses for exactly one cycle after a completing
    // transfer. hit_ch keeps the last reported channel between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_valid_r <= 1'b0;
            hit_ch_r    <= '0;
        end else if (hit_now_s) begin
            hit_valid_r <= 1'b1;
            hit_ch_r    <= gnt_idx_s;
        end else begin
            hit_valid_r <= 1'b0;
            hit_ch_r    <= hit_ch_r;
        end
    end

    // Counter read port; selects beyond the last channel read as zero.
    always_comb begin
        cnt_val_s = '0;
        if (32'(cnt_sel) < 32'(NCH)) begin
            cnt_val_s = cnt_r[cnt_sel];
        end else begin
            cnt_val_s = '0;
        end
    end

    assign in_ready  = gnt_s;
    assign hit_valid = hit_valid_r;
    assign hit_ch    = hit_ch_r;
    assign cnt_val   = cnt_val_s;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_det_scheduler
// Directed bench for seq_det_scheduler (NCH=4). A second instance with CW=2
// shares all inputs so counter saturation can be observed alongside the
// CW=8 instance. Inputs change #1 after the rising edge; outputs are checked
// away from the edge.
// -----------------------------------------------------------------------------
module tb_seq_det_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] in_valid;
    logic [3:0] in_bit;
    logic [3:0] ch_clr;
    logic [1:0] cnt_sel;

    logic [3:0] in_ready;
    logic       hit_valid;
    logic [1:0] hit_ch;
    logic [7:0] cnt_val;

    logic [3:0] in_ready_c2;
    logic       hit_valid_c2;
    logic [1:0] hit_ch_c2;
    logic [1:0] cnt_val_c2;

    int n_checks = 0;
    int n_pass   = 0;

    logic pat4 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic pat7 [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    seq_det_scheduler #(.NCH(4), .CW(8)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .ch_clr    (ch_clr),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val)
    );

    seq_det_scheduler #(.NCH(4), .CW(2)) u_dut_cw2 (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_c2),
        .ch_clr    (ch_clr),
        .hit_valid (hit_valid_c2),
        .hit_ch    (hit_ch_c2),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val_c2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit on a single channel; expect it to be accepted and check
    // the hit outcome in the following cycle.
    task automatic send(input string tag, input int ch, input logic b, input logic exp_hit);
        in_valid     = '0;
        in_bit       = '0;
        in_valid[ch] = 1'b1;
        in_bit[ch]   = b;
        #1;
        chk({tag, " rdy"}, 32'(in_ready), 32'd1 << ch);
        tick();
        chk({tag, " hit"}, 32'(hit_valid), 32'(exp_hit));
        if (exp_hit) begin
            chk({tag, " hit_ch"}, 32'(hit_ch), 32'(ch));
        end
    endtask

    task automatic read_cnt(input string tag, input int sel, input int exp);
        cnt_sel = 2'(sel);
        #1;
        chk(tag, 32'(cnt_val), 32'(exp));
    endtask

    initial begin
        int g;
        rstn     = 1'b0;
        en       = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        ch_clr   = '0;
        cnt_sel  = '0;

        // Reset state.
        #2;
        chk("rst hit_valid", 32'(hit_valid), 32'd0);
        chk("rst hit_ch", 32'(hit_ch), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        for (int s = 0; s < 4; s++) begin
            read_cnt($sformatf("rst cnt%0d", s), s, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // ch0 alone: 0,1,1,0 -> one hit after the 4th transfer.
        for (int k = 0; k < 4; k++) begin
            send($sformatf("t1 b%0d", k), 0, pat4[k], k == 3);
        end
        in_valid = '0;
        tick();
        chk("t1 hit cleared", 32'(hit_valid), 32'd0);
        read_cnt("t1 cnt0", 0, 1);

        // ch0 and ch2 together. Pointer sits at 1, so grants go 2,0,2,0,...
        // Each stream "0110" (ch0 resumes from S4, which acts like S1).
        for (int c = 0; c < 8; c++) begin
            g           = (c % 2 == 0) ? 2 : 0;
            in_valid    = 4'b0101;
            in_bit      = '0;
            in_bit[g]   = pat4[c / 2];
            #1;
            chk($sformatf("t2 c%0d rdy", c), 32'(in_ready), 32'd1 << g);
            tick();
            chk($sformatf("t2 c%0d hit", c), 32'(hit_valid), (c >= 6) ? 32'd1 : 32'd0);
            if (c >= 6) begin
                chk($sformatf("t2 c%0d hit_ch", c), 32'(hit_ch), 32'(g));
            end
        end
        in_valid = '0;
        read_cnt("t2 cnt0", 0, 2);
        read_cnt("t2 cnt2", 2, 1);

        // ch1: 0110110 -> overlapping hits after the 4th and 7th transfers.
        for (int k = 0; k < 7; k++) begin
            send($sformatf("t3 b%0d", k), 1, pat7[k], (k == 3) || (k == 6));
        end
        in_valid = '0;
        read_cnt("t3 cnt1", 1, 2);

        // ch3: 0,1,1 then clear together with a valid 0: no accept, no hit.
        for (int k = 0; k < 3; k++) begin
            send($sformatf("t4 b%0d", k), 3, pat4[k], 1'b0);
        end
        in_valid = 4'b1000;
        in_bit   = 4'b0000;
        ch_clr   = 4'b1000;
        #1;
        chk("t4 clr rdy", 32'(in_ready), 32'd0);
        tick();
        chk("t4 clr hit", 32'(hit_valid), 32'd0);
        ch_clr = '0;
        // Context restarted: this 0 must not complete a pattern.
        for (int k = 0; k < 4; k++) begin
            send($sformatf("t4 fresh b%0d", k), 3, pat4[k], k == 3);
        end
        in_valid = '0;
        read_cnt("t4 cnt3", 3, 1);
        read_cnt("t4 cnt1 kept", 1, 2);

        // en=0: no grants, pointer held; ch_clr still clears ch1.
        en       = 1'b0;
        in_valid = 4'b1111;
        ch_clr   = 4'b0010;
        #1;
        chk("t5 en0 rdy", 32'(in_ready), 32'd0);
        tick();
        chk("t5 en0 hit", 32'(hit_valid), 32'd0);
        ch_clr = '0;
        read_cnt("t5 cnt1 cleared", 1, 0);
        read_cnt("t5 cnt0 kept", 0, 2);
        en = 1'b1;
        #1;
        // Last grant went to ch3, so the pointer wrapped to 0.
        chk("t5 ptr held", 32'(in_ready), 32'd1);
        in_valid = '0;
        #1;

        // Saturation: clear ch0, then four patterns; CW=2 copy stops at 3.
        ch_clr = 4'b0001;
        tick();
        ch_clr = '0;
        read_cnt("t6 cnt0 cleared", 0, 0);
        for (int p = 1; p <= 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                send($sformatf("t6 p%0d b%0d", p, k), 0, pat4[k], k == 3);
            end
            chk($sformatf("t6 p%0d hit cw2", p), 32'(hit_valid_c2), 32'd1);
            chk($sformatf("t6 p%0d hit_ch cw2", p), 32'(hit_ch_c2), 32'd0);
            in_valid = '0;
            read_cnt($sformatf("t6 p%0d cnt0", p), 0, p);
            chk($sformatf("t6 p%0d cnt0 cw2", p), 32'(cnt_val_c2), (p > 3) ? 32'd3 : 32'(p));
        end
        chk("t6 rdy cw2 idle", 32'(in_ready_c2), 32'd0);

        // ch1 reaches S3, then reset is asserted mid-cycle.
        for (int k = 0; k < 3; k++) begin
            send($sformatf("t7 b%0d", k), 1, pat4[k], 1'b0);
        end
        rstn = 1'b0;
        #1;
        chk("t7 rst hit_valid", 32'(hit_valid), 32'd0);
        for (int s = 0; s < 4; s++) begin
            read_cnt($sformatf("t7 rst cnt%0d", s), s, 0);
        end
        rstn     = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("t7 first grant", 32'(in_ready), 32'd1);
        in_valid = 4'b0010;
        in_bit   = 4'b0000;
        #1;
        chk("t7 ch1 rdy", 32'(in_ready), 32'd2);
        tick();
        chk("t7 no hit", 32'(hit_valid), 32'd0);
        in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Time-multiplexes one "0110" serial-pattern detection engine across NCH independent bit-serial channels.
- A round-robin arbiter accepts at most one bit per cycle.
- Each channel's 3-bit detector state is saved in a per-channel context register and written back after every accepted bit.
- Hits are reported as a one-cycle pulse tagged with the channel id. Saturating per-channel hit counters are readable through a select port.

Parameters:
- NCH, 4, number of serial channels (2..16)
- CW, 8, width of each per-channel saturating hit counter
- IDW, $clog2(NCH), width of channel id fields (derived, not overridable)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  global enable; when 0, no grants are issued
- in_valid  in  NCH  per-channel bit valid
- in_bit  in  NCH  per-channel serial data bit
- in_ready  out  NCH  per-channel accept, one-hot or zero
- ch_clr  in  NCH  per-channel synchronous context clear
- hit_valid  out  1  registered pulse: pattern completed
- hit_ch  out  IDW  channel of the reported hit
- cnt_sel  in  IDW  counter read select
- cnt_val  out  CW  hit counter of channel cnt_sel (combinational read)

Behaviour:
- Reset is rstn, asynchronous, active-low; the clock is clk.
- Reset values:
  - all contexts = S0
  - round-robin pointer = 0 (channel 0 has first priority)
  - hit_valid = 0, hit_ch = 0
  - all counters = 0
- Eligibility: channel i is eligible when en=1, in_valid[i]=1 and ch_clr[i]=0.
- in_ready is combinational:
  - It is asserted for exactly one eligible channel: the first eligible at or after the pointer, in wrapping search order.
  - It is all-zero if no channel is eligible.
  - in_ready never depends on in_bit.
- Transfer = in_valid[i] & in_ready[i].
  - On a transfer, the pointer becomes (i+1) mod NCH.
  - With no transfer, the pointer holds.
- Detector states S0..S4. Transitions, given as (state: next if bit=1 / next if bit=0):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S3 / S1
  - S3: S0 / S4
  - S4: S2 / S1
  - Any undefined encoding goes to S0.
- On a transfer for channel i: ctx[i] is replaced by next(ctx[i], in_bit[i]) at the clock edge.
- If that next state is S4:
  - hit_valid=1 and hit_ch=i in the following cycle (latency 1 from transfer).
  - cnt[i] increments, saturating at 2^CW-1.
- hit_valid is 0 in every cycle not directly following a completing transfer.
- Overlap is inherent: after a hit, the stream "110" completes another hit.
- ch_clr[i]=1:
  - ctx[i] is set to S0 and cnt[i] to 0 at the edge.
  - in_ready[i] is forced 0 that cycle; clear wins over transfer, and no bit is consumed.
  - Other channels are unaffected.
- en=0: no transfers; contexts, counters and pointer hold; ch_clr still acts.
- Bit-level back-pressure is per channel. Pattern state only advances on accepted bits; idle gaps do not reset context.
- Mid-operation rstn assertion forces all reset values immediately (asynchronously). The first grant after release goes to the lowest eligible index.
- cnt_sel values ≥ NCH read 0.

Decomposition:
- Shared package seq_det_pkg holds:
  - the state encodings S0=0, S1=1, S2=2, S3=3, S4=4 (3-bit)
  - a pure function next_state(state, bit) implementing the table above
  - a HIT_STATE constant = S4
- Natural sub-module: rr_arbiter. Interface: NCH request vector, pointer register, one-hot grant, grant index, advance-on-transfer input.
- The context array, counters and hit register stay in the top.

Test Plan:
- Reset then ch0 only, bits 0,1,1,0 on consecutive cycles → in_ready[0]=1 each cycle; hit_valid=1, hit_ch=0 in the cycle after the 4th transfer; cnt_val(sel 0)=1.
- ch0 and ch2 both valid continuously, NCH=4 → grants alternate 0,2,0,2. Two interleaved "0110" streams each produce exactly one hit, with hit_ch=0 and 2 respectively.
- ch1 stream 0,1,1,0,1,1,0 → two hits on ch1, after the 4th and 7th transfers; cnt=2.
- ch3 sends 0,1,1, then ch_clr[3] is pulsed together with in_valid[3] → in_ready[3]=0 that cycle. The next bit 0 yields no hit; a fresh "0110" is needed for a hit.
- CW=2, 4 patterns on ch0 → counter reads 1,2,3,3 (saturates); hit_valid still pulses each time.
- rstn dropped mid-pattern on ch1 (state S3) with en=1 → hit_valid=0 and all counters 0 immediately. After release, bit 0 on ch1 gives no hit, and the pointer grants ch0 first when all channels are valid.
